// File: rtl/sa_drain.sv
// sa_drain: deskews the systolic-array bottom-row y bus and streams aligned result rows through a register FIFO.
// Optional signed ReLU on written lanes when SA_DRAIN_RELU_EN is defined.
module sa_drain #(
  parameter int M          = 5,
  parameter int N          = 3,
  parameter int K          = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N*DATA_WIDTH-1:0] y_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N*DATA_WIDTH-1:0] out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    overflow
);
  localparam int LAT = K;
  localparam int AW  = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int WW  = $clog2(LAT + N) + 1;
  localparam int RW  = $clog2(M) + 1;
  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, DRAIN} state_t;
  state_t state, state_n;
  logic [WW-1:0] wcnt;
  logic [RW-1:0] rcnt;
  logic [N*DATA_WIDTH-1:0] row;
  logic [N*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic lmem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic push_req, last_w, full, pop, push;
  // lane j is delayed N-1-j cycles so every lane of a row lands on the same edge
  for (genvar j = 0; j < N; j++) begin : g_lane
    localparam int D = N - 1 - j;
    logic [DATA_WIDTH-1:0] a;
    if (D == 0) begin : g_pass
      assign a = y_in[j*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] sr [D];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < D; i++) sr[i] <= '0;
        end else begin
          sr[0] <= y_in[j*DATA_WIDTH +: DATA_WIDTH];
          for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
        end
      end
      assign a = sr[D-1];
    end
`ifdef SA_DRAIN_RELU_EN
    assign row[j*DATA_WIDTH +: DATA_WIDTH] = a[DATA_WIDTH-1] ? '0 : a;
`else
    assign row[j*DATA_WIDTH +: DATA_WIDTH] = a;
`endif
  end
  assign push_req  = state == CAPTURE;
  assign last_w    = push_req && rcnt == RW'(M - 1);
  assign full      = cnt == CW'(FIFO_DEPTH);
  assign out_valid = cnt != '0;
  assign pop       = out_valid && out_ready;
  assign push      = push_req && (!full || pop);
  assign busy      = state != IDLE;
  assign out_data  = out_valid ? mem[rp] : '0;
  assign out_last  = out_valid && lmem[rp];
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = WAIT;
      WAIT:    if (wcnt == WW'(LAT + N - 3)) state_n = CAPTURE;
      CAPTURE: if (last_w) state_n = DRAIN;
      DRAIN:   if (!out_valid || (cnt == CW'(1) && pop)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wcnt     <= '0;
      rcnt     <= '0;
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      wcnt  <= state == IDLE ? '0 : state == WAIT ? wcnt + 1'b1 : wcnt;
      rcnt  <= state == IDLE ? '0 : push_req ? rcnt + 1'b1 : rcnt;
      wp    <= wp + AW'(push);
      rp    <= rp + AW'(pop);
      cnt   <= cnt + CW'(push) - CW'(pop);
      if (state == IDLE && start) overflow <= 1'b0;
      else if (push_req && !push) overflow <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp]  <= row;
      lmem[wp] <= last_w;
    end
  end
endmodule

// File: tb/tb_sa_drain.sv
// tb_sa_drain: table-driven check of sa_drain with FIFO depths 8 and 4 sharing one stimulus.
module tb_sa_drain;
  localparam int M = 5, N = 3, K = 4, DW = 32;
  localparam int BW = N * DW;
  typedef struct {
    logic          st;
    logic [BW-1:0] y;
    logic          ev;
    logic [BW-1:0] ed;
    logic          el;
    logic          eb;
  } vec_t;
  logic clk = 0, rst = 0, start = 0, rdy = 1;
  logic [BW-1:0] y_in = '0;
  logic v8, l8, b8, o8, v4, l4, b4, o4;
  logic [BW-1:0] d8, d4;
  int nvec = 0, nbad = 0, e = 0;
  vec_t tbl [14];
  always #5 clk = ~clk;
  sa_drain #(.M(M), .N(N), .K(K), .DATA_WIDTH(DW), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .y_in(y_in), .out_valid(v8), .out_ready(rdy),
    .out_data(d8), .out_last(l8), .busy(b8), .overflow(o8));
  sa_drain #(.M(M), .N(N), .K(K), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .y_in(y_in), .out_valid(v4), .out_ready(rdy),
    .out_data(d4), .out_last(l4), .busy(b4), .overflow(o4));
  function automatic logic [BW-1:0] rowv(int r);
    logic [BW-1:0] v;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = DW'(100 * r + j);
    return v;
  endfunction
  function automatic logic [BW-1:0] ybus(int rel);
    logic [BW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++)
      if (rel - 4 - j >= 0 && rel - 4 - j < M) v[j*DW +: DW] = DW'(100 * (rel - 4 - j) + j);
    return v;
  endfunction
  task automatic chk(input string nm, input logic [BW-1:0] a, input logic [BW-1:0] x);
    nvec++;
    if (a !== x) begin
      nbad++;
      $display("FAIL %s at edge %0d: got %h want %h", nm, e, a, x);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask
  task automatic step(input int rel, input logic s);
    start = s;
    y_in = ybus(rel);
    tick();
  endtask
  task automatic run_table(input logic ign);
    for (int k = 0; k < 14; k++) begin
      start = tbl[k].st || (ign && k == 3);
      y_in = tbl[k].y;
      tick();
      chk("valid8", BW'(v8), BW'(tbl[k].ev));
      chk("data8", d8, tbl[k].ed);
      chk("last8", BW'(l8), BW'(tbl[k].el));
      chk("busy8", BW'(b8), BW'(tbl[k].eb));
      chk("ovf8", BW'(o8), '0);
      chk("valid4", BW'(v4), BW'(tbl[k].ev));
      chk("data4", d4, tbl[k].ed);
      chk("last4", BW'(l4), BW'(tbl[k].el));
      chk("busy4", BW'(b4), BW'(tbl[k].eb));
      chk("ovf4", BW'(o4), '0);
    end
    start = 0;
  endtask
`ifdef SA_DRAIN_RELU_EN
  function automatic logic [BW-1:0] yrelu(int rel);
    logic [BW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++)
      if (rel - 4 - j >= 0 && rel - 4 - j < M)
        v[j*DW +: DW] = j == 0 ? 32'hFFFFFFF6 : j == 1 ? 32'd7 : 32'h80000000;
    return v;
  endfunction
`endif
  initial begin
    for (int k = 0; k < 14; k++) begin
      tbl[k].st = k == 0;
      tbl[k].y  = ybus(k);
      tbl[k].ev = k >= 6 && k <= 10;
      tbl[k].ed = (k >= 6 && k <= 10) ? rowv(k - 6) : '0;
      tbl[k].el = k == 10;
      tbl[k].eb = k <= 10;
    end
    #2 rst = 1;
    #1;
    chk("rst_valid", BW'(v8), '0);
    chk("rst_data", d8, '0);
    chk("rst_busy", BW'(b8), '0);
    chk("rst_ovf", BW'(o8), '0);
    tick();
    tick();
    rst = 0;
    tick();
    run_table(1'b0);
    run_table(1'b1);
    rdy = 0;
    for (int k = 0; k < 21; k++) begin
      rdy = k >= 15;
      step(k, k == 0);
      chk("bp_valid8", BW'(v8), BW'(k >= 6 && k <= 18));
      chk("bp_data8", d8, (k >= 6 && k <= 18) ? rowv(k <= 14 ? 0 : k - 14) : '0);
      chk("bp_last8", BW'(l8), BW'(k == 18));
      chk("bp_busy8", BW'(b8), BW'(k <= 18));
      chk("bp_ovf8", BW'(o8), '0);
      chk("of_valid4", BW'(v4), BW'(k >= 6 && k <= 17));
      chk("of_data4", d4, (k >= 6 && k <= 17) ? rowv(k <= 14 ? 0 : k - 14) : '0);
      chk("of_last4", BW'(l4), '0);
      chk("of_busy4", BW'(b4), BW'(k <= 17));
      chk("of_ovf4", BW'(o4), BW'(k >= 10));
    end
    rdy = 1;
    run_table(1'b0);
    for (int k = 0; k < 8; k++) step(k, k == 0);
    chk("pre_rst_valid", BW'(v8), 1);
    #2 rst = 1;
    #1;
    chk("mid_rst_valid8", BW'(v8), '0);
    chk("mid_rst_data8", d8, '0);
    chk("mid_rst_last8", BW'(l8), '0);
    chk("mid_rst_busy8", BW'(b8), '0);
    chk("mid_rst_ovf8", BW'(o8), '0);
    chk("mid_rst_valid4", BW'(v4), '0);
    chk("mid_rst_busy4", BW'(b4), '0);
    step(8, 1'b0);
    rst = 0;
    step(9, 1'b0);
    chk("post_rst_valid", BW'(v8), '0);
    run_table(1'b0);
`ifdef SA_DRAIN_RELU_EN
    for (int k = 0; k < 12; k++) begin
      start = k == 0;
      y_in = yrelu(k);
      tick();
      if (k >= 6 && k <= 10) chk("relu_data", d8, {32'd0, 32'd7, 32'd0});
    end
    start = 0;
`endif
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule

// File: doc/sa_drain.md
# sa_drain

Output collector for the weight-stationary systolic array. It samples the partial-sum bus leaving the bottom row of PEs and removes the one-cycle-per-column skew the array introduces. Each aligned result row is buffered in a small FIFO and delivered downstream over a valid/ready stream. It is the receiving end of the y-path that PEs forward with `y_out <= y_in + x_in*w`.

## Interface

Parameters:

- `M`, 5: result rows per tile.
- `N`, 3: array columns (lanes).
- `K`, 4: reduction depth; also the array fill latency `LAT = K`.
- `DATA_WIDTH`, 32: lane width.
- `FIFO_DEPTH`, 8: rows of buffering; must be ≥ M and a power of 2.

Ports:

- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: tile start pulse, aligned with the feeder injecting row 0.
- `y_in` in N*DATA_WIDTH: bottom-row `y_out` bus; lane j is at bits [j*DATA_WIDTH +: DATA_WIDTH].
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: downstream accept.
- `out_data` out N*DATA_WIDTH: aligned row at the FIFO head, same lane order as `y_in`.
- `out_last` out 1: head is row M-1 of the tile.
- `busy` out 1: state ≠ IDLE.
- `overflow` out 1: sticky; a row was dropped.

## Operation

- Edge numbering: the edge that samples `start`=1 in IDLE is edge 0.
- The array presents lane j of row m on `y_in` at edge `LAT+m+j`.
- Deskew:
  - Lane j passes through `N-1-j` registers; lane N-1 is unregistered.
  - Row m therefore arrives aligned at the FIFO write port at edge `LAT+N-1+m`, for m = 0..M-1.
- State machine:
  - IDLE → WAIT on `start`. This clears `overflow`, the wait counter and the row counter.
  - WAIT counts `LAT+N-1` edges, then goes to CAPTURE.
  - CAPTURE writes one row per cycle for exactly M cycles. The row with m = M-1 carries last=1 into the FIFO. After M writes it goes to DRAIN.
  - DRAIN → IDLE on the first edge where the FIFO is empty. Empty means `out_valid`=0, or the last entry is popped on that edge.
- `start` is ignored outside IDLE, including the cycle DRAIN exits.
- FIFO:
  - Storage is registers; `out_data`/`out_last` come directly from head storage, with no combinational path from `y_in`.
  - `out_valid` = not empty. A pop happens when `out_valid && out_ready`.
  - A push and pop on the same edge is legal at any occupancy, including full; the count is unchanged.
  - If full with no pop, the pushed row is dropped and `overflow` is set. The array cannot be stalled.
  - Pointers wrap modulo FIFO_DEPTH.
- Arithmetic: lanes pass through unmodified; no width change.
- Reset, including mid-tile:
  - State → IDLE; FIFO emptied; counters and deskew registers → 0.
  - All outputs → 0: `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `overflow`=0.
  - Partial tiles are discarded.

## Timing

- Fill latency: `start` edge → first FIFO write at edge `LAT+N-1`. `out_valid` rises in the following cycle.
- The first `out_data` is available `LAT+N` cycles after `start` is sampled.
- Throughput: one row per cycle in CAPTURE. With `out_ready` held at 1, rows leave one per cycle with a 1-cycle FIFO latency.
- `busy` rises the cycle after `start` is sampled. It falls the cycle after the final pop, or after the FIFO empties following CAPTURE.
- Back-to-back tiles: the next `start` is accepted no earlier than the first cycle `busy`=0.

## Configuration

- `SA_DRAIN_RELU_EN`:
  - Defined: each lane is replaced by 0 when its MSB is 1 (signed two's-complement ReLU) before the FIFO write. This is combinational, adds no latency, and is applied after deskew.
  - Undefined: lanes are written unmodified.

## Test plan

Use N=3, M=5, K=4, DATA_WIDTH=32, FIFO_DEPTH=8, and `out_ready`=1 unless stated.

- Aligned tile:
  - Stimulus: drive lane j of row m = 100*m+j at edge 4+m+j.
  - Response: writes at edges 6..10. Output rows {0,1,2},{100,101,102},...,{400,401,402} on 5 consecutive cycles; `out_last` only on {400,401,402}; `busy` drops after.
- Backpressure:
  - Stimulus: `out_ready`=0 until edge 15, then 1.
  - Response: `out_valid` holds row 0 stable from edge 7. All 5 rows are then delivered in order, no overflow.
- Overflow:
  - Stimulus: FIFO_DEPTH=4, M=5, `out_ready`=0 throughout.
  - Response: row 4 is dropped and `overflow`=1 from edge 11. After `out_ready`=1, rows 0–3 are delivered with no `out_last`, then IDLE. The next `start` clears `overflow`.
- Reset mid-tile:
  - Stimulus: assert `rst` at edge 8.
  - Response: all outputs 0 immediately, FIFO empty. A new `start` then yields a clean tile identical to the aligned-tile case.
- Ignored start:
  - Stimulus: pulse `start` again at edge 3.
  - Response: no effect on timing or data of the first tile.
- ReLU (`SA_DRAIN_RELU_EN` defined):
  - Stimulus: lane value 0xFFFFFFF6 (-10).
  - Response: output 0; lane value 7 outputs 7.
